// File: rtl/conv_pkg.sv
// Shared definitions for the conv layer scheduler: word width, constant clog2 and FSM encoding.
package conv_pkg;

    localparam int FP32_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/conv_lane_fifo.sv
// Per-filter output lane: small power-of-two FIFO with combinational head and occupancy count.
module conv_lane_fifo
    import conv_pkg::*;
#(
    parameter int  DATA_WIDTH = FP32_WIDTH,
    parameter int  DEPTH      = 4,
    localparam int PTR_W      = (DEPTH > 1) ? clog2(DEPTH) : 1,
    localparam int CNT_W      = clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic [CNT_W-1:0]      count_o,
    output logic                  full_o,
    output logic                  empty_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_q;
    logic [PTR_W-1:0]      rd_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic                  do_push;
    logic                  do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];

    // A pop in the same cycle frees the slot, so a push onto a full lane still lands.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/conv_layer_scheduler.sv
// Sequences one conv2d layer frame: gates the shared input FIFO, throttles the filters and
// serialises the per-filter output lanes pixel-major onto one ready/valid stream.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | waiting for start; late filter words still land in lanes
//  ST_RUN   | feeding the padded frame to the filters
//  ST_DRAIN | all input consumed, emptying lanes until the last word
//  ST_DONE  | one-cycle done pulse, then back to idle
module conv_layer_scheduler
    import conv_pkg::*;
#(
    parameter int  DATA_WIDTH   = FP32_WIDTH,
    parameter int  NUM_FILTERS  = 8,
    parameter int  WIDTH        = 112,
    parameter int  LANE_DEPTH   = 4,
    parameter int  THROTTLE_LVL = 2,
    localparam int IDX_W        = (NUM_FILTERS > 1) ? clog2(NUM_FILTERS) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic                              err_ovf,
    input  logic                              in_empty,
    output logic                              in_rdreq,
    output logic                              fm_empty,
    input  logic [NUM_FILTERS-1:0]            fm_rdreq,
    input  logic [NUM_FILTERS-1:0]            fm_valid,
    input  logic [NUM_FILTERS*DATA_WIDTH-1:0] fm_data,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic [IDX_W-1:0]                  out_idx,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_last
);

    localparam int IN_WORDS  = (WIDTH + 2) * (WIDTH + 2);
    localparam int OUT_WORDS = WIDTH * WIDTH * NUM_FILTERS;
    localparam int IN_W      = clog2(IN_WORDS + 1);
    localparam int OUT_W     = clog2(OUT_WORDS + 1);
    localparam int LCNT_W    = clog2(LANE_DEPTH + 1);

    state_e           state_q;
    logic [IN_W-1:0]  in_cnt_q;
    logic [OUT_W-1:0] out_cnt_q;
    logic [IDX_W-1:0] rr_q;
    logic [IDX_W-1:0] rr_d;
    logic             busy_q;
    logic             done_q;
    logic             err_ovf_q;

    logic [DATA_WIDTH-1:0] lane_head [NUM_FILTERS];
    logic [LCNT_W-1:0]     lane_cnt  [NUM_FILTERS];
    logic [NUM_FILTERS-1:0] lane_full;
    logic [NUM_FILTERS-1:0] lane_empty;
    logic [NUM_FILTERS-1:0] lane_pop;

    logic throttle;
    logic xfer;
    logic ovf_hit;
    logic in_last;
    logic out_done;
    logic rdreq_unused;

    for (genvar k = 0; k < NUM_FILTERS; k++) begin : g_lane
        conv_lane_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (LANE_DEPTH)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .push_i  (fm_valid[k]),
            .pop_i   (lane_pop[k]),
            .data_i  (fm_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .head_o  (lane_head[k]),
            .count_o (lane_cnt[k]),
            .full_o  (lane_full[k]),
            .empty_o (lane_empty[k])
        );
    end

    // Filters run in lockstep, so only lane 0's request paces the shared FIFO.
    assign rdreq_unused = ^fm_rdreq;

    always_comb begin
        throttle = 1'b0;
        for (int k = 0; k < NUM_FILTERS; k++) begin
            if (lane_cnt[k] >= LCNT_W'(THROTTLE_LVL)) begin
                throttle = 1'b1;
            end
        end
    end

    assign fm_empty = (state_q != ST_RUN) | in_empty | throttle;
    assign in_rdreq = fm_rdreq[0] & ~fm_empty;

    assign out_valid = ~lane_empty[rr_q];
    assign out_data  = lane_head[rr_q];
    assign out_idx   = rr_q;
    assign xfer      = out_valid & out_ready;
    assign out_last  = out_valid & (out_cnt_q == OUT_W'(OUT_WORDS - 1));

    always_comb begin
        lane_pop = '0;
        for (int k = 0; k < NUM_FILTERS; k++) begin
            lane_pop[k] = xfer & (rr_q == IDX_W'(k));
        end
    end

    always_comb begin
        rr_d = rr_q + 1'b1;
        if (rr_q == IDX_W'(NUM_FILTERS - 1)) begin
            rr_d = '0;
        end
    end

    assign ovf_hit  = |(fm_valid & lane_full & ~lane_pop);
    assign in_last  = in_rdreq & (in_cnt_q == IN_W'(IN_WORDS - 1));
    assign out_done = (out_last & out_ready) | (out_cnt_q == OUT_W'(OUT_WORDS));

    assign busy    = busy_q;
    assign done    = done_q;
    assign err_ovf = err_ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            rr_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_ovf_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (xfer) begin
                rr_q <= rr_d;
            end
            if (ovf_hit) begin
                err_ovf_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_RUN;
                        busy_q    <= 1'b1;
                        in_cnt_q  <= '0;
                        out_cnt_q <= '0;
                        err_ovf_q <= ovf_hit;
                    end
                end
                ST_RUN: begin
                    if (in_rdreq) begin
                        in_cnt_q <= in_cnt_q + 1'b1;
                    end
                    if (xfer) begin
                        out_cnt_q <= out_cnt_q + 1'b1;
                    end
                    if (in_last) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (xfer) begin
                        out_cnt_q <= out_cnt_q + 1'b1;
                    end
                    if (out_done) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Randomised bench for conv_layer_scheduler with 3-cycle lockstep filter models and a queue-level reference.
module tb_conv_layer_scheduler;

    localparam int DW = 32;
    localparam int NF = 2;
    localparam int W  = 4;
    localparam int PW = W + 2;
    localparam int N_IN  = PW * PW;
    localparam int N_OUT = W * W * NF;
    localparam int DEPTH = 4;
    localparam int THR   = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          err_ovf;
    logic          in_empty;
    logic          in_rdreq;
    logic          fm_empty;
    logic [NF-1:0] fm_rdreq;
    logic [NF-1:0] fm_valid;
    logic [NF*DW-1:0] fm_data;
    logic [DW-1:0] out_data;
    logic [0:0]    out_idx;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    conv_layer_scheduler #(
        .DATA_WIDTH   (DW),
        .NUM_FILTERS  (NF),
        .WIDTH        (W),
        .LANE_DEPTH   (DEPTH),
        .THROTTLE_LVL (THR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .err_ovf   (err_ovf),
        .in_empty  (in_empty),
        .in_rdreq  (in_rdreq),
        .fm_empty  (fm_empty),
        .fm_rdreq  (fm_rdreq),
        .fm_valid  (fm_valid),
        .fm_data   (fm_data),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // reference model state
    logic [DW-1:0] lq0[$];
    logic [DW-1:0] lq1[$];
    logic [DW-1:0] pix_data [NF][W*W];
    int  m_rr;
    bit  m_active;
    bit  m_done_now;
    bit  m_err;
    int  m_reads;
    int  m_xfers;
    int  pend;
    int  pend_pix;

    // stimulus control and observed counters
    int  ie_mode;
    int  rdy_pct;
    int  stall_left;
    bit  stall_last;
    bit  tgl;
    bit  req_start;
    logic [NF-1:0] fv_force;
    logic [DW-1:0] force_data;
    int  dut_reads;
    int  dut_xfers;
    int  dut_dones;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lsize(input int k);
        return (k == 0) ? lq0.size() : lq1.size();
    endfunction

    function automatic logic [DW-1:0] lhead(input int k);
        return (k == 0) ? lq0[0] : lq1[0];
    endfunction

    task automatic model_reset();
        lq0.delete();
        lq1.delete();
        m_rr = 0;
        m_active = 1'b0;
        m_done_now = 1'b0;
        m_err = 1'b0;
        m_reads = 0;
        m_xfers = 0;
        pend = 0;
        pend_pix = 0;
    endtask

    task automatic reset_dut(input int cycles);
        rst = 1'b1;
        start = 1'b0;
        fm_valid = '0;
        fm_data = '0;
        fm_rdreq = '1;
        in_empty = 1'b0;
        out_ready = 1'b0;
        model_reset();
        repeat (cycles) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_ovf, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_in_rdreq", in_rdreq, 0);
        chk("rst_fm_empty", fm_empty, 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_idx", out_idx, 0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic step();
        logic fv;
        logic thr_e, fe_e, rd_e, val_e, last_e, xfer_e, ovf;
        bit   was_idle;
        int   w, r, c, k;

        fv = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) fv = 1'b1;
        end
        fm_valid = fv ? '1 : fv_force;
        fm_data  = fv ? {pix_data[1][pend_pix], pix_data[0][pend_pix]} : {force_data, force_data};
        fm_rdreq = (pend == 0 && !fv) ? '1 : '0;
        case (ie_mode)
            1:       begin tgl = ~tgl; in_empty = tgl; end
            2:       in_empty = ($urandom_range(99) < 30);
            default: in_empty = 1'b0;
        endcase
        if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
            stall_last = (stall_left == 0);
        end else begin
            out_ready = ($urandom_range(99) < rdy_pct);
            stall_last = 1'b0;
        end
        start = req_start;
        req_start = 1'b0;

        @(negedge clk);
        was_idle = !m_active && !m_done_now;
        thr_e  = (lq0.size() >= THR) || (lq1.size() >= THR);
        fe_e   = !(m_active && m_reads < N_IN) || in_empty || thr_e;
        rd_e   = fm_rdreq[0] && !fe_e;
        val_e  = lsize(m_rr) > 0;
        last_e = val_e && m_active && (m_xfers == N_OUT - 1);
        xfer_e = val_e && out_ready;

        chk("fm_empty", fm_empty, fe_e);
        chk("in_rdreq", in_rdreq, rd_e);
        chk("out_valid", out_valid, val_e);
        chk("out_idx", out_idx, m_rr);
        chk("out_last", out_last, last_e);
        chk("busy", busy, m_active || m_done_now);
        chk("done", done, m_done_now);
        chk("err_ovf", err_ovf, m_err);
        if (val_e) chk("out_data", out_data, lhead(m_rr));
        if (in_empty) chk("rdreq_gated", in_rdreq, 0);
        if (stall_last) chk("stall_throttle", fm_empty, 1);
        if (xfer_e && m_active) begin
            chk("order_idx", out_idx, m_xfers % NF);
            chk("order_data", out_data, pix_data[m_xfers % NF][m_xfers / NF]);
        end

        if (in_rdreq) dut_reads++;
        if (out_valid && out_ready) dut_xfers++;
        if (done) dut_dones++;

        if (rd_e) begin
            w = m_reads;
            m_reads++;
            r = w / PW;
            c = w % PW;
            if (r >= 2 && c >= 2) begin
                pend = 3;
                pend_pix = (r - 2) * W + (c - 2);
            end
        end
        if (xfer_e) begin
            if (m_rr == 0) void'(lq0.pop_front());
            else           void'(lq1.pop_front());
            m_rr = (m_rr + 1) % NF;
        end
        ovf = 1'b0;
        for (k = 0; k < NF; k++) begin
            if (fm_valid[k]) begin
                if (lsize(k) < DEPTH) begin
                    if (k == 0) lq0.push_back(fm_data[k*DW +: DW]);
                    else        lq1.push_back(fm_data[k*DW +: DW]);
                end else begin
                    ovf = 1'b1;
                end
            end
        end
        if (ovf) m_err = 1'b1;
        if (m_done_now) m_done_now = 1'b0;
        if (xfer_e && m_active) begin
            m_xfers++;
            if (m_xfers == N_OUT) begin
                m_active = 1'b0;
                m_done_now = 1'b1;
            end
        end
        if (start && was_idle) begin
            m_active = 1'b1;
            m_reads = 0;
            m_xfers = 0;
            m_err = ovf;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int ie, input int rdy, input int stall_at, input int abort_at);
        int  cyc;
        bit  stalled, extra, aborted;
        for (int f = 0; f < NF; f++)
            for (int p = 0; p < W * W; p++)
                pix_data[f][p] = $urandom;
        ie_mode = ie;
        rdy_pct = rdy;
        dut_reads = 0;
        dut_xfers = 0;
        dut_dones = 0;
        stalled = 1'b0;
        extra = 1'b0;
        aborted = 1'b0;
        req_start = 1'b1;
        step();
        chk("err_clr", err_ovf, 0);
        cyc = 0;
        while ((m_active || m_done_now) && cyc < 3000) begin
            if (abort_at >= 0 && dut_xfers == abort_at) begin
                reset_dut(1);
                aborted = 1'b1;
                break;
            end
            if (stall_at >= 0 && !stalled && dut_xfers >= stall_at) begin
                stall_left = 20;
                stalled = 1'b1;
            end
            if (!extra && dut_xfers == 5) begin
                req_start = 1'b1;
                extra = 1'b1;
            end
            step();
            cyc++;
        end
        if (cyc >= 3000) chk("frame_timeout", m_active, 0);
        if (aborted) begin
            repeat (4) step();
            chk("abort_no_done", dut_dones, 0);
        end else begin
            chk("n_rdreq", dut_reads, N_IN);
            chk("n_xfer", dut_xfers, N_OUT);
            chk("n_done", dut_dones, 1);
            step();
            chk("idle_busy", busy, 0);
        end
    endtask

    initial begin
        ie_mode = 0;
        rdy_pct = 0;
        stall_left = 0;
        stall_last = 1'b0;
        tgl = 1'b0;
        req_start = 1'b0;
        fv_force = '0;
        force_data = '0;
        dut_reads = 0;
        dut_xfers = 0;
        dut_dones = 0;
        reset_dut(3);
        repeat (2) step();

        run_frame(0, 100, -1, -1);
        run_frame(0, 100, 4, -1);
        run_frame(1, 70, -1, -1);
        run_frame(2, 50, -1, -1);

        // late words in idle: overflow lane 1, then fill lane 0 and drain both
        ie_mode = 0;
        rdy_pct = 0;
        for (int i = 0; i < 5; i++) begin
            fv_force = 2'b10;
            force_data = $urandom;
            step();
        end
        chk("err_set", err_ovf, 1);
        for (int i = 0; i < 4; i++) begin
            fv_force = 2'b01;
            force_data = $urandom;
            step();
        end
        fv_force = '0;
        repeat (3) step();
        chk("err_sticky", err_ovf, 1);
        rdy_pct = 100;
        repeat (12) step();
        chk("idle_drain", out_valid, 0);

        run_frame(2, 80, -1, 10);
        run_frame(0, 60, -1, -1);
        run_frame(2, 40, 8, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
